// File: rtl/pa_rvfpm_pkg.sv
// Shared FPU/XIF types: result and commit packets plus the per-id commit state
// used by the result gate.
package pa_rvfpm;

   localparam int unsigned XIF_ID_WIDTH = 4;
   localparam int unsigned XIF_FLEN     = 32;

   typedef struct packed {
      logic [XIF_ID_WIDTH-1:0] id;
      logic [XIF_FLEN-1:0]     data;
      logic [4:0]              rd;
      logic                    we;
      logic [2:0]              ecswe;
      logic [5:0]              ecsdata;
      logic                    exc;
      logic [5:0]              exccode;
      logic                    err;
      logic                    dbg;
   } x_result_t;

   typedef struct packed {
      logic [XIF_ID_WIDTH-1:0] id;
      logic                    commit_kill;
   } x_commit_t;

   typedef enum logic [1:0] {
      PEND = 2'b00,
      CMT  = 2'b01,
      KILL = 2'b10
   } commit_state_e;

endpackage

// File: rtl/xif_sync_fifo.sv
// In-order synchronous FIFO, type-parameterised; head is visible on dout while
// not empty. Occupancy is a registered count, so full/empty never look ahead.
module xif_sync_fifo #(
   parameter type         T     = logic,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     ck,
   input  logic                     rst,
   input  logic                     push,
   input  T                         din,
   input  logic                     pop,
   output T                         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   T             mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked entirely by count.
   always_ff @(posedge ck) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fpu_result_gate.sv
// Holds FPU results in order and releases each to the core only once its id is
// committed; killed ids are popped and dropped with a one-cycle drop_pulse.
module fpu_result_gate
   import pa_rvfpm::*;
#(
   parameter int unsigned X_ID_WIDTH = XIF_ID_WIDTH,
   parameter int unsigned FLEN       = XIF_FLEN,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                   ck,
   input  logic                   rst,
   input  logic                   s_result_valid,
   output logic                   s_result_ready,
   input  x_result_t              s_result,
   input  logic                   commit_valid,
   input  x_commit_t              commit,
   output logic                   result_valid,
   input  logic                   result_ready,
   output x_result_t              result,
   output logic [$clog2(DEPTH):0] count,
   output logic                   drop_pulse
);

   localparam int unsigned NUM_IDS = 2 ** X_ID_WIDTH;

   if (X_ID_WIDTH != XIF_ID_WIDTH || FLEN != XIF_FLEN) begin : g_bad_cfg
      $error("fpu_result_gate: X_ID_WIDTH/FLEN must match the pa_rvfpm packet types");
   end

   x_result_t     head;
   logic          full;
   logic          empty;
   logic          pop;
   commit_state_e tbl [NUM_IDS];
   commit_state_e head_state;

   xif_sync_fifo #(
      .T     (x_result_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .ck    (ck),
      .rst   (rst),
      .push  (s_result_valid),
      .din   (s_result),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign s_result_ready = !full;
   assign head_state     = tbl[head.id];

   always_comb begin
      result_valid = 1'b0;
      drop_pulse   = 1'b0;
      pop          = 1'b0;
      if (!empty) begin
         case (head_state)
            CMT: begin
               result_valid = 1'b1;
               pop          = result_ready;
            end
            KILL: begin
               drop_pulse = 1'b1;
               pop        = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign result = result_valid ? head : '0;

   // Commit write is applied last so it wins over the pop clear on the same id.
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_IDS; i++) tbl[i] <= PEND;
      end else begin
         if (pop) tbl[head.id] <= PEND;
         if (commit_valid) tbl[commit.id] <= commit.commit_kill ? KILL : CMT;
      end
   end

endmodule

// File: tb/tb_fpu_result_gate.sv
// Bench for fpu_result_gate: directed vector table, hand sequences for full and
// reset, and random traffic against a queue-based reference model.
module tb_fpu_result_gate;
   import pa_rvfpm::*;

   logic      ck;
   logic      rst;
   logic      s_result_valid;
   logic      s_result_ready;
   x_result_t s_result;
   logic      commit_valid;
   x_commit_t commit;
   logic      result_valid;
   logic      result_ready;
   x_result_t result;
   logic [2:0] count;
   logic      drop_pulse;

   int total;
   int bad;

   fpu_result_gate #(.X_ID_WIDTH(4), .FLEN(32), .DEPTH(4)) dut (
      .ck             (ck),
      .rst            (rst),
      .s_result_valid (s_result_valid),
      .s_result_ready (s_result_ready),
      .s_result       (s_result),
      .commit_valid   (commit_valid),
      .commit         (commit),
      .result_valid   (result_valid),
      .result_ready   (result_ready),
      .result         (result),
      .count          (count),
      .drop_pulse     (drop_pulse)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   // ---------------- reference model ----------------
   x_result_t     mq [$];
   commit_state_e mst [16];

   function automatic void model_reset();
      mq.delete();
      for (int i = 0; i < 16; i++) mst[i] = PEND;
   endfunction

   function automatic void model_update();
      logic popm;
      logic pushm;
      popm  = 1'b0;
      pushm = s_result_valid && (mq.size() < 4);
      if (mq.size() > 0) begin
         if (mst[mq[0].id] == KILL) popm = 1'b1;
         if (mst[mq[0].id] == CMT && result_ready) popm = 1'b1;
      end
      if (popm) begin
         mst[mq[0].id] = PEND;
         mq.delete(0);
      end
      if (pushm) mq.push_back(s_result);
      if (commit_valid) mst[commit.id] = commit.commit_kill ? KILL : CMT;
   endfunction

   function automatic x_result_t mkpkt(input logic [3:0] id);
      x_result_t p;
      p         = '0;
      p.id      = id;
      p.data    = 32'h3F80_0000 + ((32'(id) ^ 32'd3) << 4);
      p.rd      = 5'(id) + 5'd2;
      p.we      = 1'b1;
      p.exc     = id[0];
      p.exccode = {2'b00, id};
      p.dbg     = id[1];
      return p;
   endfunction

   function automatic x_commit_t mkcmt(input logic [3:0] id, input logic kill);
      x_commit_t c;
      c.id          = id;
      c.commit_kill = kill;
      return c;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: model follows the edge the DUT just saw, then new inputs are
   // driven on the falling edge and outputs settle for checking.
   task automatic cyc(input logic sv, input x_result_t sp, input logic cv,
                      input x_commit_t cp, input logic rr);
      @(posedge ck);
      if (rst) model_update();
      @(negedge ck);
      s_result_valid = sv;
      s_result       = sp;
      commit_valid   = cv;
      commit         = cp;
      result_ready   = rr;
      #1;
   endtask

   task automatic idle(input logic rr);
      cyc(1'b0, '0, 1'b0, '0, rr);
   endtask

   task automatic chk_model(input string tag);
      logic      e_rv;
      logic      e_drop;
      x_result_t e_res;
      e_rv   = 1'b0;
      e_drop = 1'b0;
      e_res  = '0;
      if (mq.size() > 0) begin
         e_rv   = (mst[mq[0].id] == CMT);
         e_drop = (mst[mq[0].id] == KILL);
         if (e_rv) e_res = mq[0];
      end
      chk({tag, ".result_valid"}, 64'(result_valid), 64'(e_rv));
      chk({tag, ".drop_pulse"}, 64'(drop_pulse), 64'(e_drop));
      chk({tag, ".count"}, 64'(count), 64'(mq.size()));
      chk({tag, ".s_result_ready"}, 64'(s_result_ready), 64'(mq.size() < 4));
      chk({tag, ".result"}, 64'(result), 64'(e_res));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       sv;
      logic [3:0] sid;
      logic       cv;
      logic [3:0] cid;
      logic       ck;
      logic       e_rv;
      logic [3:0] e_id;
      logic [2:0] e_cnt;
      logic       e_drop;
   } vec_t;

   vec_t vecs [25];

   function automatic vec_t mkv(input logic sv, input logic [3:0] sid, input logic cv,
                                input logic [3:0] cid, input logic kl, input logic e_rv,
                                input logic [3:0] e_id, input logic [2:0] e_cnt,
                                input logic e_drop);
      vec_t v;
      v.sv = sv; v.sid = sid; v.cv = cv; v.cid = cid; v.ck = kl;
      v.e_rv = e_rv; v.e_id = e_id; v.e_cnt = e_cnt; v.e_drop = e_drop;
      return v;
   endfunction

   initial begin
      total = 0;
      bad   = 0;
      rst            = 1'b0;
      s_result_valid = 1'b0;
      s_result       = '0;
      commit_valid   = 1'b0;
      commit         = '0;
      result_ready   = 1'b0;
      model_reset();

      // basic pass
      vecs[0]  = mkv(1, 3, 0, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mkv(0, 0, 1, 3, 0, 0, 0, 1, 0);
      vecs[2]  = mkv(0, 0, 0, 0, 0, 1, 3, 1, 0);
      vecs[3]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // commit before result
      vecs[4]  = mkv(0, 0, 1, 7, 0, 0, 0, 0, 0);
      vecs[5]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[6]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[7]  = mkv(1, 7, 0, 0, 0, 0, 0, 0, 0);
      vecs[8]  = mkv(0, 0, 0, 0, 0, 1, 7, 1, 0);
      vecs[9]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // kill drop
      vecs[10] = mkv(1, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[11] = mkv(1, 2, 0, 0, 0, 0, 0, 1, 0);
      vecs[12] = mkv(0, 0, 1, 1, 1, 0, 0, 2, 0);
      vecs[13] = mkv(0, 0, 1, 2, 0, 0, 0, 2, 1);
      vecs[14] = mkv(0, 0, 0, 0, 0, 1, 2, 1, 0);
      vecs[15] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // head-of-line blocking
      vecs[16] = mkv(1, 4, 0, 0, 0, 0, 0, 0, 0);
      vecs[17] = mkv(1, 5, 0, 0, 0, 0, 0, 1, 0);
      vecs[18] = mkv(0, 0, 1, 5, 0, 0, 0, 2, 0);
      vecs[19] = mkv(0, 0, 0, 0, 0, 0, 0, 2, 0);
      vecs[20] = mkv(0, 0, 0, 0, 0, 0, 0, 2, 0);
      vecs[21] = mkv(0, 0, 1, 4, 0, 0, 0, 2, 0);
      vecs[22] = mkv(0, 0, 0, 0, 0, 1, 4, 2, 0);
      vecs[23] = mkv(0, 0, 0, 0, 0, 1, 5, 1, 0);
      vecs[24] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);

      #12;
      chk("reset.result_valid", 64'(result_valid), 64'd0);
      chk("reset.count", 64'(count), 64'd0);
      chk("reset.s_result_ready", 64'(s_result_ready), 64'd1);
      chk("reset.drop_pulse", 64'(drop_pulse), 64'd0);
      chk("reset.result", 64'(result), 64'd0);
      @(negedge ck);
      rst = 1'b1;

      for (int i = 0; i < 25; i++) begin
         cyc(vecs[i].sv, mkpkt(vecs[i].sid), vecs[i].cv, mkcmt(vecs[i].cid, vecs[i].ck), 1'b1);
         chk($sformatf("vec%0d.result_valid", i), 64'(result_valid), 64'(vecs[i].e_rv));
         chk($sformatf("vec%0d.count", i), 64'(count), 64'(vecs[i].e_cnt));
         chk($sformatf("vec%0d.drop_pulse", i), 64'(drop_pulse), 64'(vecs[i].e_drop));
         chk($sformatf("vec%0d.s_result_ready", i), 64'(s_result_ready), 64'd1);
         chk($sformatf("vec%0d.result", i), 64'(result),
             vecs[i].e_rv ? 64'(mkpkt(vecs[i].e_id)) : 64'd0);
      end

      // full / backpressure
      for (int k = 0; k < 4; k++) cyc(1'b0, '0, 1'b1, mkcmt(4'(8 + k), 1'b0), 1'b0);
      for (int k = 0; k < 4; k++) cyc(1'b1, mkpkt(4'(8 + k)), 1'b0, '0, 1'b0);
      cyc(1'b1, mkpkt(4'd12), 1'b0, '0, 1'b0);
      chk("full.s_result_ready", 64'(s_result_ready), 64'd0);
      chk("full.count", 64'(count), 64'd4);
      chk("full.result_valid", 64'(result_valid), 64'd1);
      for (int k = 0; k < 3; k++) begin
         idle(1'b0);
         chk("full.count_hold", 64'(count), 64'd4);
         chk("full.result_stable", 64'(result), 64'(mkpkt(4'd8)));
      end
      for (int k = 0; k < 4; k++) begin
         idle(1'b1);
         chk("drain.result_valid", 64'(result_valid), 64'd1);
         chk("drain.result", 64'(result), 64'(mkpkt(4'(8 + k))));
         chk("drain.count", 64'(count), 64'(4 - k));
      end
      idle(1'b1);
      chk("drain.empty_count", 64'(count), 64'd0);
      chk("drain.empty_valid", 64'(result_valid), 64'd0);

      // async reset mid-stream
      cyc(1'b0, '0, 1'b1, mkcmt(4'd6, 1'b0), 1'b0);
      cyc(1'b0, '0, 1'b1, mkcmt(4'd13, 1'b0), 1'b0);
      cyc(1'b1, mkpkt(4'd6), 1'b0, '0, 1'b0);
      cyc(1'b1, mkpkt(4'd14), 1'b0, '0, 1'b0);
      idle(1'b0);
      chk("prerst.result_valid", 64'(result_valid), 64'd1);
      chk("prerst.count", 64'(count), 64'd2);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      chk("rst.result_valid", 64'(result_valid), 64'd0);
      chk("rst.count", 64'(count), 64'd0);
      chk("rst.s_result_ready", 64'(s_result_ready), 64'd1);
      chk("rst.result", 64'(result), 64'd0);
      @(negedge ck);
      rst = 1'b1;
      cyc(1'b1, mkpkt(4'd13), 1'b0, '0, 1'b1);
      idle(1'b1);
      chk("postrst.wait_valid", 64'(result_valid), 64'd0);
      chk("postrst.count", 64'(count), 64'd1);
      idle(1'b1);
      chk("postrst.still_wait", 64'(result_valid), 64'd0);
      cyc(1'b0, '0, 1'b1, mkcmt(4'd13, 1'b0), 1'b1);
      idle(1'b1);
      chk("postrst.valid", 64'(result_valid), 64'd1);
      chk("postrst.result", 64'(result), 64'(mkpkt(4'd13)));
      idle(1'b1);
      chk("postrst.drained", 64'(count), 64'd0);

      // random traffic against the model
      for (int n = 0; n < 500; n++) begin
         x_result_t rp;
         rp = x_result_t'({$urandom, $urandom});
         rp.id = 4'($urandom_range(0, 3));
         cyc(($urandom_range(0, 9) < 6), rp, ($urandom_range(0, 9) < 3),
             mkcmt(4'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0)),
             ($urandom_range(0, 9) < 6));
         chk_model($sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
